// File: rtl/tmds_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_encoder_pkg
//  Purpose  : Shared constants and helpers for the DVI TMDS encoder:
//             character width, disparity counter width, control tokens.
//  Revision : 1.0  initial release
// ============================================================================
package tmds_encoder_pkg;

    localparam int CHAR_W = 10;
    localparam int CNT_W  = 5;

    // Control-period tokens indexed by {C1, C0}; bit 0 is transmitted first
    localparam logic [CHAR_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [CHAR_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [CHAR_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [CHAR_W-1:0] CTRL_11 = 10'b1010101011;

    // Number of set bits in a byte (0..8)
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, v[i]};
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_channel
//  Purpose  : One TMDS 8b/10b lane. Stage 1 builds the transition-minimised
//             q_m word; stage 2 applies DC balancing against the running
//             disparity counter or emits a control token during blanking.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_channel #(
    parameter int CNT_W = tmds_encoder_pkg::CNT_W
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [7:0]                          d,
    input  logic                                c1,
    input  logic                                c0,
    input  logic                                de,
    output logic [tmds_encoder_pkg::CHAR_W-1:0] q
);
    import tmds_encoder_pkg::*;

    // Stage-1 combinational
    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic              w_bit;
    logic [8:0]        w_qm;

    // Stage-1 registers
    logic [8:0]        r_qm;
    logic              r_de;
    logic [1:0]        r_c;

    // Stage-2 combinational
    logic [3:0]        w_n1q;
    logic [CNT_W-1:0]  w_diff;      // n1q - n0q, two's complement
    logic              w_cnt_zero;
    logic              w_cnt_pos;
    logic              w_cnt_neg;
    logic [CHAR_W-1:0] w_q_next;
    logic [CNT_W-1:0]  w_cnt_next;

    // Stage-2 registers
    logic [CNT_W-1:0]  r_cnt;

    // Transition-minimising stage: pick XOR/XNOR chain from the byte's weight
    always_comb begin
        w_n1d      = popcount8(d);
        w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
        w_qm       = 9'd0;
        w_bit      = d[0];
        w_qm[0]    = w_bit;
        for (int i = 1; i < 8; i++) begin
            w_bit   = w_use_xnor ? ~(w_bit ^ d[i]) : (w_bit ^ d[i]);
            w_qm[i] = w_bit;
        end
        w_qm[8] = ~w_use_xnor;
    end

    // Stage-1 pipeline register: q_m, enable and control bits travel together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_qm <= 9'd0;
            r_de <= 1'b0;
            r_c  <= 2'b00;
        end else begin
            r_qm <= w_qm;
            r_de <= de;
            r_c  <= {c1, c0};
        end
    end

    // DC-balancing selection; modular CNT_W arithmetic, blanking clears the count
    always_comb begin
        w_n1q      = popcount8(r_qm[7:0]);
        w_diff     = CNT_W'({w_n1q, 1'b0}) - CNT_W'(8);
        w_cnt_zero = (r_cnt == '0);
        w_cnt_neg  = r_cnt[CNT_W-1];
        w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;
        w_q_next   = CTRL_00;
        w_cnt_next = '0;
        if (!r_de) begin
            case (r_c)
                2'b00:   w_q_next = CTRL_00;
                2'b01:   w_q_next = CTRL_01;
                2'b10:   w_q_next = CTRL_10;
                default: w_q_next = CTRL_11;
            endcase
        end else if (w_cnt_zero || (w_n1q == 4'd4)) begin
            w_q_next   = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
            w_cnt_next = r_cnt + (r_qm[8] ? w_diff : -w_diff);
        end else if ((w_cnt_pos && (w_n1q > 4'd4)) || (w_cnt_neg && (w_n1q < 4'd4))) begin
            w_q_next   = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt + CNT_W'({r_qm[8], 1'b0}) - w_diff;
        end else begin
            w_q_next   = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt + w_diff - CNT_W'({~r_qm[8], 1'b0});
        end
    end

    // Stage-2 register: output character and running disparity
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            r_cnt <= '0;
        end else begin
            q     <= w_q_next;
            r_cnt <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_encoder
//  Purpose  : DVI TMDS encoder, three lanes. Blue carries HSYNC/VSYNC in
//             control periods; green and red carry C1C0=00. Two-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_encoder #(
    parameter int CNT_W = 5
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [7:0]                          red,
    input  logic [7:0]                          green,
    input  logic [7:0]                          blue,
    input  logic                                hsync,
    input  logic                                vsync,
    input  logic                                ve,
    output logic [tmds_encoder_pkg::CHAR_W-1:0] tmds_ch0,
    output logic [tmds_encoder_pkg::CHAR_W-1:0] tmds_ch1,
    output logic [tmds_encoder_pkg::CHAR_W-1:0] tmds_ch2
);
    import tmds_encoder_pkg::*;

    tmds_channel #(.CNT_W(CNT_W)) u_ch0 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (blue),
        .c1      (vsync),
        .c0      (hsync),
        .de      (ve),
        .q       (tmds_ch0)
    );

    tmds_channel #(.CNT_W(CNT_W)) u_ch1 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (green),
        .c1      (1'b0),
        .c0      (1'b0),
        .de      (ve),
        .q       (tmds_ch1)
    );

    tmds_channel #(.CNT_W(CNT_W)) u_ch2 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (red),
        .c1      (1'b0),
        .c0      (1'b0),
        .de      (ve),
        .q       (tmds_ch2)
    );

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_encoder
//  Purpose  : Self-checking bench for tmds_encoder: directed vector table,
//             reset corner cases and randomized pixels against a reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmds_encoder;
    import tmds_encoder_pkg::*;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] red     = 8'd0;
    logic [7:0] green   = 8'd0;
    logic [7:0] blue    = 8'd0;
    logic       hsync   = 1'b0;
    logic       vsync   = 1'b0;
    logic       ve      = 1'b0;
    logic [9:0] tmds_ch0;
    logic [9:0] tmds_ch1;
    logic [9:0] tmds_ch2;

    always #5 clock = ~clock;

    tmds_encoder #(.CNT_W(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .hsync    (hsync),
        .vsync    (vsync),
        .ve       (ve),
        .tmds_ch0 (tmds_ch0),
        .tmds_ch1 (tmds_ch1),
        .tmds_ch2 (tmds_ch2)
    );

    typedef struct packed {
        logic            de;
        logic [2:0][7:0] d;     // [0]=blue [1]=green [2]=red
        logic [2:0][9:0] ch;
        logic [2:0][7:0] cnt;   // disparity after this character
    } exp_t;

    typedef struct packed {
        logic            de;
        logic            hs;
        logic            vs;
        logic [7:0]      r;
        logic [7:0]      g;
        logic [7:0]      b;
        logic [2:0][9:0] ch;
    } vec_t;

    exp_t expq[$];
    int   mcnt [3];
    int   tests = 0;
    int   fails = 0;

    // Reference encoder: weight-based XOR/XNOR choice, then balance the
    // running ones/zeros disparity kept as a plain integer
    function automatic logic [9:0] model_enc(input int k, input logic [7:0] d,
                                             input logic [1:0] c, input logic de);
        logic [8:0] qm;
        logic       x;
        int         n1, n1q, n0q;
        logic [9:0] o;
        if (!de) begin
            mcnt[k] = 0;
            case (c)
                2'b00:   return 10'b1101010100;
                2'b01:   return 10'b0010101011;
                2'b10:   return 10'b0101010100;
                default: return 10'b1010101011;
            endcase
        end
        n1 = $countones(d);
        x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~x;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (mcnt[k] == 0 || n1q == n0q) begin
            o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            mcnt[k] += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((mcnt[k] > 0 && n1q > n0q) || (mcnt[k] < 0 && n0q > n1q)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            mcnt[k] += 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            mcnt[k] += (n1q - n0q) - (qm[8] ? 0 : 2);
        end
        return o;
    endfunction

    // Receiver-side decode of a data character back to its byte
    function automatic logic [7:0] decode(input logic [9:0] c);
        logic [7:0] v, d;
        v    = c[9] ? ~c[7:0] : c[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = c[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    function automatic int dut_cnt(input int k);
        case (k)
            0:       return int'($signed(dut.u_ch0.r_cnt));
            1:       return int'($signed(dut.u_ch1.r_cnt));
            default: return int'($signed(dut.u_ch2.r_cnt));
        endcase
    endfunction

    task automatic check(input exp_t f);
        logic [2:0][9:0] act;
        int              c;
        act = {tmds_ch2, tmds_ch1, tmds_ch0};
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (act[k] !== f.ch[k]) begin
                fails++;
                $display("FAIL char ch%0d: got %b expected %b", k, act[k], f.ch[k]);
            end
            c = dut_cnt(k);
            tests++;
            if (c != int'($signed(f.cnt[k]))) begin
                fails++;
                $display("FAIL cnt ch%0d: got %0d expected %0d", k, c, $signed(f.cnt[k]));
            end
            tests++;
            if (c > 8 || c < -8) begin
                fails++;
                $display("FAIL cnt_bound ch%0d: got %0d expected within -8..8", k, c);
            end
            if (f.de) begin
                tests++;
                if (decode(act[k]) !== f.d[k]) begin
                    fails++;
                    $display("FAIL decode ch%0d: got %h expected %h", k, decode(act[k]), f.d[k]);
                end
            end
        end
    endtask

    // One pixel clock: check the character due now, drive the next input
    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic use_tab, input logic [2:0][9:0] tab);
        exp_t e;
        if (expq.size() == 2) check(expq.pop_front());
        ve = de; hsync = hs; vsync = vs; red = r; green = g; blue = b;
        e.de    = de;
        e.d     = {r, g, b};
        e.ch[0] = model_enc(0, b, {vs, hs}, de);
        e.ch[1] = model_enc(1, g, 2'b00, de);
        e.ch[2] = model_enc(2, r, 2'b00, de);
        for (int k = 0; k < 3; k++) e.cnt[k] = 8'(mcnt[k]);
        if (use_tab) e.ch = tab;
        expq.push_back(e);
        @(negedge clock);
    endtask

    // Assert reset at a falling edge, check outputs clear at once, release
    task automatic do_reset(input int ncyc);
        exp_t e;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({tmds_ch2, tmds_ch1, tmds_ch0} !== 30'd0) begin
            fails++;
            $display("FAIL reset_async: got %h %h %h expected 0", tmds_ch2, tmds_ch1, tmds_ch0);
        end
        repeat (ncyc) begin
            ve = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
            red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
            @(negedge clock);
        end
        tests++;
        if ({tmds_ch2, tmds_ch1, tmds_ch0} !== 30'd0) begin
            fails++;
            $display("FAIL reset_hold: got %h %h %h expected 0", tmds_ch2, tmds_ch1, tmds_ch0);
        end
        reset_n = 1'b1;
        expq.delete();
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        // First character after release comes from the cleared stage-1 registers
        e.de  = 1'b0;
        e.d   = '0;
        e.ch  = {CTRL_00, CTRL_00, CTRL_00};
        e.cnt = '0;
        expq.push_back(e);
    endtask

    function automatic vec_t mkv(input logic de, input logic hs, input logic vs,
                                 input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs; v.r = r; v.g = g; v.b = b;
        v.ch = {c2, c1, c0};
        return v;
    endfunction

    vec_t tab [13];

    initial begin
        int remaining;
        int run;
        logic vrun;

        tab[0]  = mkv(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'b1101010100, 10'b1101010100, 10'b1101010100);
        tab[1]  = mkv(0, 1, 0, 8'h00, 8'h00, 8'h00, 10'b0010101011, 10'b1101010100, 10'b1101010100);
        tab[2]  = mkv(0, 1, 1, 8'h00, 8'h00, 8'h00, 10'b1010101011, 10'b1101010100, 10'b1101010100);
        tab[3]  = mkv(0, 0, 1, 8'h00, 8'h00, 8'h00, 10'b0101010100, 10'b1101010100, 10'b1101010100);
        tab[4]  = mkv(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'b0100000000, 10'b0100000000, 10'b0100000000);
        tab[5]  = mkv(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'b1111111111, 10'b1111111111, 10'b1111111111);
        tab[6]  = mkv(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'b0100000000, 10'b0100000000, 10'b0100000000);
        tab[7]  = mkv(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'b1101010100, 10'b1101010100, 10'b1101010100);
        tab[8]  = mkv(1, 0, 0, 8'h00, 8'hFF, 8'h00, 10'b0100000000, 10'b1000000000, 10'b0100000000);
        tab[9]  = mkv(0, 1, 0, 8'h00, 8'h00, 8'h00, 10'b0010101011, 10'b1101010100, 10'b1101010100);
        tab[10] = mkv(1, 0, 0, 8'h01, 8'h01, 8'h01, 10'b0111111111, 10'b0111111111, 10'b0111111111);
        tab[11] = mkv(1, 0, 0, 8'h01, 8'h01, 8'h01, 10'b1100000000, 10'b1100000000, 10'b1100000000);
        tab[12] = mkv(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'b1101010100, 10'b1101010100, 10'b1101010100);

        @(negedge clock);
        do_reset(3);

        // Directed vectors: tokens, disparity walk, XNOR path, case B
        for (int i = 0; i < 13; i++)
            step(tab[i].de, tab[i].hs, tab[i].vs, tab[i].r, tab[i].g, tab[i].b, 1'b1, tab[i].ch);

        // Mid-line reset with a non-zero disparity in flight
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        do_reset(1);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1,
             {10'b0100000000, 10'b0100000000, 10'b0100000000});
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1,
             {10'b1111111111, 10'b1111111111, 10'b1111111111});
        step(0, 1, 1, 8'h00, 8'h00, 8'h00, 1'b0, '0);

        // Randomized pixels in alternating ve runs
        remaining = 20000;
        vrun      = 1'b1;
        while (remaining > 0) begin
            run = int'($urandom_range(1, 2000));
            if (run > remaining) run = remaining;
            repeat (run)
                step(vrun, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 1'b0, '0);
            remaining -= run;
            vrun = ~vrun;
        end

        // Flush the pipeline so every queued character is checked
        step(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        step(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Consumes the registered pixel/sync stream produced by the HDMI timing core: red/green/blue, hsync, vsync, ve.
- Produces three 10-bit TMDS characters per pixel clock, using DVI 1.0 8b/10b with running-disparity DC balance.
- Output feeds the 10:1 serializer/OSERDES stage.
- DVI mode only: control periods carry sync tokens; no data islands.

Parameters:
- CNT_W, 5: width of each channel's signed running-disparity counter. Range is -16..+15; the observed range is -8..+8.

Ports:
- clock  in  1  pixel clock, same domain as the timing core.
- reset_n  in  1  asynchronous active-low reset.
- red  in  8  pixel red, qualified by ve.
- green  in  8  pixel green, qualified by ve.
- blue  in  8  pixel blue, qualified by ve.
- hsync  in  1  horizontal sync, already at final polarity.
- vsync  in  1  vertical sync, already at final polarity.
- ve  in  1  video enable; 1 means active pixel.
- tmds_ch0  out  10  blue channel character; carries C0=hsync, C1=vsync. Bit 0 is transmitted first.
- tmds_ch1  out  10  green channel character; C1C0=00.
- tmds_ch2  out  10  red channel character; C1C0=00.

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low; it is asserted asynchronously and released synchronously upstream.
- Reset values: all pipeline registers 0, all tmds_chN=10'b0, all disparity counters 0.
- Latency: fixed 2 cycles from input to tmds_chN for every input, ve=0 or 1. All three channels are cycle-aligned.
- Stage 1 (registered):
  - n1d = popcount(D).
  - Use XNOR if n1d>4, or if n1d==4 and D[0]==0; otherwise XOR.
  - q_m[0]=D[0]; q_m[i]=q_m[i-1] XOR/XNOR D[i] for i=1..7.
  - q_m[8]=1 for XOR, 0 for XNOR.
  - Register q_m[8:0], ve, and C1C0.
- Stage 2 (registered): n1q/n0q = ones/zeros in q_m[7:0]; cnt = the channel's disparity counter.
  - Case A, cnt==0 or n1q==n0q:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (n1q-n0q) : (n0q-n1q).
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m8, ~q_m[7:0]}.
    - cnt += 2*q_m8 + (n0q-n1q).
  - Case C, otherwise:
    - out = {0, q_m8, q_m[7:0]}.
    - cnt += (n1q-n0q) - 2*(~q_m8).
- Control period (stage-2 ve=0):
  - C1C0=00 -> 10'b1101010100
  - C1C0=01 -> 10'b0010101011
  - C1C0=10 -> 10'b0101010100
  - C1C0=11 -> 10'b1010101011
  - cnt forced to 0.
- Arithmetic: all count arithmetic is signed CNT_W bits with no saturation. Disparity never exceeds ±8 with correct encoding; a bench assertion checks this.
- ve edges: the first active pixel after blanking always encodes with cnt=0. The ve 1->0 transition emits a control token on the very next character; there are no guard bands or preambles.
- Mid-operation reset: outputs go to 0 immediately (asynchronous). After release, the first valid character appears 2 cycles after the first sampled input.
- No handshake: the block is a free-running pipeline that accepts one input every cycle.

Decomposition:
- Shared package holds:
  - the four control-token constants (CTRL_00, CTRL_01, CTRL_10, CTRL_11);
  - the character width constant (10);
  - CNT_W.
- Sub-module tmds_channel (one per colour, three instances):
  - inputs d[7:0], c1, c0, de;
  - output q[9:0];
  - owns its stage-1 and stage-2 registers and its disparity counter.
- The top level only wires channels and ties c1/c0 of ch1/ch2 to 0.

Test Plan:
1. Reset:
   - Stimulus: hold reset_n=0 while applying arbitrary inputs.
   - Response: tmds_ch0/1/2 = 0. Release, then ve=0, hsync=0, vsync=0 -> all channels 1101010100 from cycle 2.
2. Sync tokens:
   - Stimulus: ve=0, hsync=1, vsync=0.
   - Response: ch0=0010101011 two cycles later.
   - Stimulus: hsync=1, vsync=1.
   - Response: ch0=1010101011; ch1=ch2=1101010100 throughout.
3. Disparity walk:
   - Stimulus: after blanking, ve=1, blue=0x00 for three pixels.
   - Response: ch0 = 0100000000 (cnt -8), 1111111111 (cnt +2), 0100000000 (cnt -6).
4. XNOR path:
   - Stimulus: after blanking, ve=1, green=0xFF.
   - Response: ch1=1000000000, cnt=-8.
   - Stimulus: next ve=0.
   - Response: ch1=1101010100 and cnt returns to 0.
5. Random compare:
   - Stimulus: 20000 random pixels with random ve runs of 1..2000 cycles.
   - Response: every character matches the behavioural reference model at 2-cycle latency; |cnt| ≤ 8 at all times; each decoded character equals the input pixel.
6. Reset mid-line:
   - Stimulus: pulse reset_n low for 1 cycle during ve=1 with cnt≠0.
   - Response: outputs 0 immediately; after release the first active pixel encodes as from cnt=0, e.g. blue=0x00 -> 0100000000.
